// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    // Controller states: normal issue, or front end frozen behind a mul/div
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    // sll $0,$0,0 -- what IF/ID holds after a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_match.sv
// One operand-vs-writer dependency compare. $0 is hard-wired, so it never creates a hazard.
module hazard_match
    import pipeline_ctrl_pkg::*;
(
    input  logic       i_uses,
    input  logic [4:0] i_src,
    input  logic [4:0] i_dst,
    input  logic       i_regwrite,
    output logic       o_match
);

    // Dependency exists only if the operand is really read and really written
    assign o_match = i_uses && (i_src != REG_ZERO) && (i_src == i_dst) && i_regwrite;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: RAW stalls, branch/jump
// flushes, mul/div freeze and saturating stall/flush event counters.
// Build option: FORWARDING_EN -- when defined, EX forwarding exists and only load-use stalls.
//
//  state   | meaning
//  RUN     | normal issue; flush > mul/div start > data stall
//  MD_BUSY | mul/div owns Execute; front end and ID/EX frozen until the down-counter hits 1
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic             UsesRs_D,
    input  logic             UsesRt_D,
    input  logic             RegWrite_E,
    input  logic             MemRead_E,
    input  logic [4:0]       WriteReg_E,
    input  logic             RegWrite_M,
    input  logic [4:0]       WriteReg_M,
    input  logic             BranchTaken_E,
    input  logic             Jump_E,
    input  logic             MulDivStart_E,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int              MD_W    = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);
    localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);

    state_t           r_state;
    logic [MD_W-1:0]  r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_rs_e;
    logic w_rt_e;
    logic w_data_stall;
    logic w_flush;

    hazard_match u_rs_e (.i_uses(UsesRs_D), .i_src(Rs_D), .i_dst(WriteReg_E),
                         .i_regwrite(RegWrite_E), .o_match(w_rs_e));
    hazard_match u_rt_e (.i_uses(UsesRt_D), .i_src(Rt_D), .i_dst(WriteReg_E),
                         .i_regwrite(RegWrite_E), .o_match(w_rt_e));

`ifdef FORWARDING_EN
    // Forwarding covers ALU producers; only a load in Execute cannot be bypassed in time
    logic w_unused_mem;
    assign w_unused_mem = ^{RegWrite_M, WriteReg_M};
    assign w_data_stall = MemRead_E && (w_rs_e || w_rt_e);
`else
    // No bypass: wait until the producer leaves Memory (write-first regfile covers WB)
    logic w_rs_m;
    logic w_rt_m;
    logic w_unused_load;

    hazard_match u_rs_m (.i_uses(UsesRs_D), .i_src(Rs_D), .i_dst(WriteReg_M),
                         .i_regwrite(RegWrite_M), .o_match(w_rs_m));
    hazard_match u_rt_m (.i_uses(UsesRt_D), .i_src(Rt_D), .i_dst(WriteReg_M),
                         .i_regwrite(RegWrite_M), .o_match(w_rt_m));

    assign w_unused_load = MemRead_E;
    assign w_data_stall  = w_rs_e || w_rt_e || w_rs_m || w_rt_m;
`endif

    assign w_flush = BranchTaken_E || Jump_E;

    // Zero-latency enables: pipeline registers sample these at the same edge
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXWrite  = 1'b1;
        IDEXFlush  = 1'b0;
        MulDivBusy = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_flush) begin
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end else if (!MulDivStart_E && w_data_stall) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
            end
            MD_BUSY: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                MulDivBusy = 1'b1;
            end
            default: ;
        endcase
    end

    // State, mul/div down-counter and saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_md_cnt    <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_flush) begin
                        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                    end else if (MulDivStart_E) begin
                        r_state  <= MD_BUSY;
                        r_md_cnt <= MD_LOAD;
                    end else if (w_data_stall) begin
                        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                    end
                end
                MD_BUSY: begin
                    r_md_cnt <= r_md_cnt - MD_ONE;
                    if (r_md_cnt == MD_ONE) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a randomized
// run against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TB_MD    = 4;
    localparam int TB_CNT_W = 4;
    localparam int SAT      = (1 << TB_CNT_W) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs_D, Rt_D, WriteReg_E, WriteReg_M;
    logic UsesRs_D, UsesRt_D, RegWrite_E, MemRead_E, RegWrite_M;
    logic BranchTaken_E, Jump_E, MulDivStart_E;
    logic PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy;
    logic [TB_CNT_W-1:0] StallCount, FlushCount;

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining freeze cycles and plain integer event counts
    int m_busy_left = 0;
    int m_stall     = 0;
    int m_flush     = 0;
    bit e_pcw, e_ifidw, e_ifidf, e_idexw, e_idexf, e_busy;
    bit e_do_flush, e_do_md, e_do_stall;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(TB_MD), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .UsesRs_D(UsesRs_D), .UsesRt_D(UsesRt_D),
        .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .WriteReg_E(WriteReg_E),
        .RegWrite_M(RegWrite_M), .WriteReg_M(WriteReg_M),
        .BranchTaken_E(BranchTaken_E), .Jump_E(Jump_E), .MulDivStart_E(MulDivStart_E),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXWrite(IDEXWrite), .IDEXFlush(IDEXFlush), .MulDivBusy(MulDivBusy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    function automatic bit depends(input logic uses, input logic [4:0] src);
        bit e_hit, m_hit;
        if (!uses || src == 5'd0) return 1'b0;
        e_hit = RegWrite_E && (src == WriteReg_E) && (FWD ? MemRead_E : 1'b1);
        m_hit = !FWD && RegWrite_M && (src == WriteReg_M);
        return e_hit || m_hit;
    endfunction

    task automatic model_eval();
        e_do_flush = 0; e_do_md = 0; e_do_stall = 0;
        if (m_busy_left > 0) begin
            {e_pcw, e_ifidw, e_ifidf, e_idexw, e_idexf, e_busy} = 6'b000001;
        end else begin
            {e_pcw, e_ifidw, e_ifidf, e_idexw, e_idexf, e_busy} = 6'b110100;
            if (BranchTaken_E || Jump_E) begin
                e_do_flush = 1; e_ifidf = 1; e_idexf = 1;
            end else if (MulDivStart_E) begin
                e_do_md = 1;
            end else if (depends(UsesRs_D, Rs_D) || depends(UsesRt_D, Rt_D)) begin
                e_do_stall = 1; e_pcw = 0; e_ifidw = 0; e_idexf = 1;
            end
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_busy_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (e_do_flush) begin
            if (m_flush < SAT) m_flush++;
        end else if (e_do_md) begin
            m_busy_left = TB_MD - 1;
        end else if (e_do_stall) begin
            if (m_stall < SAT) m_stall++;
        end
    endtask

    task automatic idle();
        reset = 0; Rs_D = 0; Rt_D = 0; UsesRs_D = 0; UsesRt_D = 0;
        RegWrite_E = 0; MemRead_E = 0; WriteReg_E = 0; RegWrite_M = 0; WriteReg_M = 0;
        BranchTaken_E = 0; Jump_E = 0; MulDivStart_E = 0;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic load_use_rs8();
        MemRead_E = 1; RegWrite_E = 1; WriteReg_E = 5'd8; Rs_D = 5'd8; UsesRs_D = 1;
    endtask

    task automatic test_reset();
        do_reset(); #1;
        checks++;
        if ({PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy} !== 6'b110100) begin
            failures++;
            $display("FAIL reset_enables got=%b want=110100",
                     {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy});
        end
        checks++;
        if (StallCount !== '0 || FlushCount !== '0) begin
            failures++;
            $display("FAIL reset_counters stall=%0d flush=%0d want=0/0", StallCount, FlushCount);
        end
    endtask

    task automatic test_load_use();
        do_reset(); load_use_rs8(); #1;
        checks++;
        if ({PCWrite, IFIDWrite, IDEXFlush, IDEXWrite} !== 4'b0011) begin
            failures++;
            $display("FAIL load_use_enables pcw/ifidw/idexf/idexw=%b want=0011",
                     {PCWrite, IFIDWrite, IDEXFlush, IDEXWrite});
        end
        tick(); idle(); #1;
        checks++;
        if (StallCount !== 4'd1 || PCWrite !== 1'b1) begin
            failures++;
            $display("FAIL load_use_after stall=%0d pcw=%b want=1/1", StallCount, PCWrite);
        end
    endtask

    task automatic test_zero_reg();
        do_reset(); MemRead_E = 1; RegWrite_E = 1; WriteReg_E = 5'd0; Rs_D = 5'd0;
        UsesRs_D = 1; RegWrite_M = 1; WriteReg_M = 5'd0; #1;
        checks++;
        if (PCWrite !== 1'b1 || IDEXFlush !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg pcw=%b idexf=%b want=1/0", PCWrite, IDEXFlush);
        end
        tick(); idle(); #1;
        checks++;
        if (StallCount !== 4'd0) begin
            failures++;
            $display("FAIL zero_reg_count stall=%0d want=0", StallCount);
        end
    endtask

    task automatic test_flush_priority();
        do_reset(); load_use_rs8(); BranchTaken_E = 1; #1;
        checks++;
        if ({IFIDFlush, IDEXFlush, PCWrite} !== 3'b111) begin
            failures++;
            $display("FAIL flush_prio ifidf/idexf/pcw=%b want=111", {IFIDFlush, IDEXFlush, PCWrite});
        end
        tick(); idle(); Jump_E = 1; #1;
        checks++;
        if (StallCount !== 4'd0 || FlushCount !== 4'd1) begin
            failures++;
            $display("FAIL flush_prio_counts stall=%0d flush=%0d want=0/1", StallCount, FlushCount);
        end
        tick(); idle(); #1;
        checks++;
        if (FlushCount !== 4'd2) begin
            failures++;
            $display("FAIL jump_flush_count flush=%0d want=2", FlushCount);
        end
    endtask

    task automatic test_muldiv();
        do_reset(); MulDivStart_E = 1; #1;
        checks++;
        if ({PCWrite, IFIDWrite, IDEXWrite, MulDivBusy} !== 4'b1110) begin
            failures++;
            $display("FAIL md_start pcw/ifidw/idexw/busy=%b want=1110",
                     {PCWrite, IFIDWrite, IDEXWrite, MulDivBusy});
        end
        tick(); idle();
        for (int i = 0; i < TB_MD - 1; i++) begin
            load_use_rs8(); BranchTaken_E = 1; #1;
            checks++;
            if ({PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy} !== 6'b000001) begin
                failures++;
                $display("FAIL md_busy cycle=%0d got=%b want=000001", i,
                         {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy});
            end
            tick(); idle();
        end
        #1;
        checks++;
        if (MulDivBusy !== 1'b0 || PCWrite !== 1'b1 || FlushCount !== 4'd0 || StallCount !== 4'd0) begin
            failures++;
            $display("FAIL md_exit busy=%b pcw=%b flush=%0d stall=%0d want=0/1/0/0",
                     MulDivBusy, PCWrite, FlushCount, StallCount);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset(); load_use_rs8(); tick(); idle();
        MulDivStart_E = 1; tick(); idle();
        tick();
        reset = 1; tick(); reset = 0; #1;
        checks++;
        if ({PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy} !== 6'b110100 ||
            StallCount !== '0 || FlushCount !== '0) begin
            failures++;
            $display("FAIL reset_mid_busy got=%b stall=%0d flush=%0d want=110100/0/0",
                     {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy},
                     StallCount, FlushCount);
        end
    endtask

    task automatic test_alu_dependency();
        int stalls;
        do_reset(); stalls = 0;
        RegWrite_E = 1; WriteReg_E = 5'd9; Rt_D = 5'd9; UsesRt_D = 1; #1;
        stalls += (PCWrite === 1'b0);
        tick();
        RegWrite_E = 0; WriteReg_E = 5'd0; RegWrite_M = 1; WriteReg_M = 5'd9; #1;
        stalls += (PCWrite === 1'b0);
        tick();
        RegWrite_M = 0; WriteReg_M = 5'd0; #1;
        stalls += (PCWrite === 1'b0);
        checks++;
        if (stalls != (FWD ? 0 : 2) || StallCount !== TB_CNT_W'(FWD ? 0 : 2)) begin
            failures++;
            $display("FAIL alu_dep stall_cycles=%0d count=%0d want=%0d", stalls, StallCount,
                     FWD ? 0 : 2);
        end
        tick(); idle();
    endtask

    task automatic test_saturation();
        do_reset(); load_use_rs8();
        for (int i = 0; i < SAT + 5; i++) tick();
        #1;
        checks++;
        if (StallCount !== TB_CNT_W'(SAT) || PCWrite !== 1'b0) begin
            failures++;
            $display("FAIL stall_saturate count=%0d pcw=%b want=%0d/0", StallCount, PCWrite, SAT);
        end
        idle();
    endtask

    task automatic test_random();
        logic [5:0] obs, exp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(199) == 0);
            Rs_D          = 5'($urandom_range(3));
            Rt_D          = 5'($urandom_range(3));
            UsesRs_D      = 1'($urandom);
            UsesRt_D      = 1'($urandom);
            RegWrite_E    = 1'($urandom);
            MemRead_E     = 1'($urandom);
            WriteReg_E    = 5'($urandom_range(3));
            RegWrite_M    = 1'($urandom);
            WriteReg_M    = 5'($urandom_range(3));
            BranchTaken_E = ($urandom_range(11) == 0);
            Jump_E        = ($urandom_range(15) == 0);
            MulDivStart_E = ($urandom_range(13) == 0);
            #1;
            model_eval();
            obs = {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MulDivBusy};
            exp = {e_pcw, e_ifidw, e_ifidf, e_idexw, e_idexf, e_busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rand_enables cycle=%0d got=%b want=%b", n, obs, exp);
            end
            checks++;
            if (StallCount !== TB_CNT_W'(m_stall) || FlushCount !== TB_CNT_W'(m_flush)) begin
                failures++;
                $display("FAIL rand_counters cycle=%0d stall=%0d/%0d flush=%0d/%0d", n,
                         StallCount, m_stall, FlushCount, m_flush);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_flush_priority();
        test_muldiv();
        test_reset_mid_busy();
        test_alu_dependency();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
